// File: rtl/memio_pkg.sv
// Shared types and constants for the memory-controller IO register block.
// Bit numbering follows the bus convention: bit 0 is the most significant data bit.
package memio_pkg;

    localparam int CTRL_W = 4;
    localparam int REG_W  = 18;
    localparam int ADDR_W = CTRL_W + REG_W;
    localparam int DATA_W = 36;

    typedef logic [14:14+ADDR_W-1] ioaddr_t;
    typedef logic [0:DATA_W-1]     word_t;

    localparam ioaddr_t MSR_ADDR_DEFAULT = 22'o0100000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_ACK1   = 3'd4,
        ST_ACK2   = 3'd5,
        ST_WAIT   = 3'd6
    } state_t;

    // A request is ours only on a full address hit with exactly one direction set.
    function automatic logic io_decode_ok(input ioaddr_t addr, input ioaddr_t msr,
                                          input logic rd, input logic wr);
        return (addr == msr) && (rd ^ wr);
    endfunction

endpackage

// File: rtl/mem_ioreg_if.sv
// IO bus request/acknowledge bundle between a bus master and the MSR IO block.
interface mem_ioreg_if;
    import memio_pkg::*;

    logic    busREQI;
    logic    busIO;
    logic    busREAD;
    logic    busWRITE;
    ioaddr_t busADDRI;
    word_t   busDATAI;
    logic    busACKO;
    word_t   busDATAO;

    modport master (
        output busREQI, busIO, busREAD, busWRITE, busADDRI, busDATAI,
        input  busACKO, busDATAO
    );

    modport slave (
        input  busREQI, busIO, busREAD, busWRITE, busADDRI, busDATAI,
        output busACKO, busDATAO
    );

endinterface

// File: rtl/mem_ioreg.sv
// IO-bus front end for the Memory Status Register: decodes one address, strobes
// writes into the MSR, returns a stable snapshot of it on reads. Falling-edge clocked.
module mem_ioreg
    import memio_pkg::*;
#(
    parameter ioaddr_t MSR_ADDR = MSR_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    mem_ioreg_if.slave  bus,
    input  word_t       regSTAT,
    output logic        msrWRITE,
    output word_t       msrDATA
);

    state_t  state_q;
    ioaddr_t addr_q;
    word_t   wdata_q;
    logic    rd_q;
    logic    wr_q;
    word_t   rdat_q;
    logic    msr_write_q;
    word_t   msr_data_q;
    logic    ack_q;
    word_t   datao_q;

    // Transaction FSM with its capture registers and registered bus/MSR outputs.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rdat_q      <= '0;
            msr_write_q <= 1'b0;
            msr_data_q  <= '0;
            ack_q       <= 1'b0;
            datao_q     <= '0;
        end else begin
            msr_write_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ack_q   <= 1'b0;
                    datao_q <= '0;
                    if (bus.busREQI && bus.busIO) begin
                        addr_q  <= bus.busADDRI;
                        wdata_q <= bus.busDATAI;
                        rd_q    <= bus.busREAD;
                        wr_q    <= bus.busWRITE;
                        state_q <= ST_DECODE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    // Anything not ours is left unanswered so the bus times out.
                    if (io_decode_ok(addr_q, MSR_ADDR, rd_q, wr_q)) begin
                        state_q <= rd_q ? ST_READ : ST_WRITE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WRITE: begin
                    msr_write_q <= 1'b1;
                    msr_data_q  <= wdata_q;
                    state_q     <= ST_ACK1;
                end
                ST_READ: begin
                    rdat_q  <= regSTAT;
                    state_q <= ST_ACK1;
                end
                ST_ACK1: begin
                    ack_q   <= 1'b1;
                    datao_q <= rd_q ? rdat_q : '0;
                    state_q <= ST_ACK2;
                end
                ST_ACK2: begin
                    ack_q   <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    ack_q   <= 1'b0;
                    datao_q <= '0;
                    // A still-held request must not be captured a second time.
                    if (!bus.busREQI) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    datao_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign msrWRITE     = msr_write_q;
    assign msrDATA      = msr_data_q;
    assign bus.busACKO  = ack_q;
    assign bus.busDATAO = datao_q;

endmodule
